mac_tile_reducer: RTL and testbench

Consumer of the 4-array pipeline's MAC output stream. It row-reduces each TILE_SIZE×TILE_SIZE result tile and accumulates the row sums across COL_BLOCKS consecutive column beats. At the end of each tile it requantizes the accumulated vector to DATA_WIDTH fixed point and queues it in a 2-entry FIFO behind a valid/ready interface to the memory controller. It also cross-checks the pipeline's tile-completion pulse against its own beat count.

---
 rtl/mac_tile_reducer.sv | 160 ++++++++++++++++
 tb/tb_mac_tile_reducer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_reducer.sv
// Row-reduces MAC result tiles across COL_BLOCKS beats, requantizes each finished tile
// to DATA_WIDTH fixed point and queues it in a 2-entry FIFO with sticky error flags.
module mac_tile_reducer #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int COL_BLOCKS = 16
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [2:0]                                         mode,
    input  logic                                               valid_in,
    input  logic                                               done_tile_in,
    input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] tile_in,
    input  logic                                               err_clr,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]               out_vec,
    output logic                                               out_sat,
    output logic [7:0]                                         out_tag,
    output logic                                               err_sync,
    output logic                                               err_ovf
);

    localparam int SUM_W = ACC_WIDTH + $clog2(TILE_SIZE) + $clog2(COL_BLOCKS);
    localparam int CNT_W = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
    localparam logic signed [SUM_W:0] Q_MAX = (SUM_W+1)'((longint'(1) << (DATA_WIDTH-1)) - 1);
    localparam logic signed [SUM_W:0] Q_MIN = -Q_MAX - 1;
    localparam logic signed [SUM_W:0] RND   = (SUM_W+1)'(longint'(1) << (FRAC_BITS-1));

    typedef struct packed {
        logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec;
        logic                                 sat;
        logic [7:0]                           tag;
    } entry_t;

    logic signed [SUM_W-1:0] acc_q [TILE_SIZE];
    logic signed [SUM_W-1:0] acc_d [TILE_SIZE];
    logic signed [SUM_W-1:0] row_sum [TILE_SIZE];
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]              tile_cnt_q, tile_cnt_d;
    logic                    expect_done_q, expect_done_d;
    logic                    err_sync_q, err_sync_d;
    logic                    err_ovf_q, err_ovf_d;
    entry_t                  fifo_q [2];
    entry_t                  fifo_d [2];
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [1:0]              wr_cnt;
    entry_t                  new_entry;
    logic                    beat, last_beat, abort, pop, push, drop, sync_set;

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            row_sum[i] = '0;
            for (int j = 0; j < TILE_SIZE; j++) begin
                row_sum[i] = row_sum[i] + SUM_W'($signed(tile_in[i][j]));
            end
        end
    end

    // One extra bit of headroom so the rounding constant can never wrap the final sum.
    always_comb begin : requant
        logic signed [SUM_W-1:0] final_sum;
        logic signed [SUM_W:0]   rounded;
        logic signed [SUM_W:0]   q_wide;
        new_entry     = '0;
        new_entry.tag = tile_cnt_q;
        for (int i = 0; i < TILE_SIZE; i++) begin
            final_sum = acc_q[i] + row_sum[i];
            rounded   = {final_sum[SUM_W-1], final_sum} + RND;
            q_wide    = rounded >>> FRAC_BITS;
            if (q_wide > Q_MAX) begin
                new_entry.vec[i] = Q_MAX[DATA_WIDTH-1:0];
                new_entry.sat    = 1'b1;
            end else if (q_wide < Q_MIN) begin
                new_entry.vec[i] = Q_MIN[DATA_WIDTH-1:0];
                new_entry.sat    = 1'b1;
            end else begin
                new_entry.vec[i] = q_wide[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        beat      = (mode == 3'b000) && valid_in;
        last_beat = beat && (beat_cnt_q == CNT_W'(COL_BLOCKS - 1));
        abort     = (mode != 3'b000) && (beat_cnt_q != '0);
        pop       = (fifo_cnt_q != 2'd0) && out_ready;
        push      = last_beat && ((fifo_cnt_q != 2'd2) || pop);
        drop      = last_beat && (fifo_cnt_q == 2'd2) && !pop;
        sync_set  = abort || (done_tile_in != expect_done_q);

        for (int i = 0; i < TILE_SIZE; i++) begin
            if (abort || last_beat) acc_d[i] = '0;
            else if (beat)          acc_d[i] = acc_q[i] + row_sum[i];
            else                    acc_d[i] = acc_q[i];
        end

        if (abort || last_beat) beat_cnt_d = '0;
        else if (beat)          beat_cnt_d = beat_cnt_q + 1'b1;
        else                    beat_cnt_d = beat_cnt_q;

        tile_cnt_d    = last_beat ? tile_cnt_q + 8'd1 : tile_cnt_q;
        expect_done_d = last_beat;

        if (sync_set)     err_sync_d = 1'b1;
        else if (err_clr) err_sync_d = 1'b0;
        else              err_sync_d = err_sync_q;

        if (drop)         err_ovf_d = 1'b1;
        else if (err_clr) err_ovf_d = 1'b0;
        else              err_ovf_d = err_ovf_q;
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward before the push lands.
    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        wr_cnt    = fifo_cnt_q - {1'b0, pop};
        if (pop) fifo_d[0] = fifo_q[1];
        if (push) begin
            if (wr_cnt == 2'd0) fifo_d[0] = new_entry;
            else                fifo_d[1] = new_entry;
        end
        fifo_cnt_d = wr_cnt + {1'b0, push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TILE_SIZE; i++) acc_q[i] <= '0;
            beat_cnt_q    <= '0;
            tile_cnt_q    <= '0;
            expect_done_q <= 1'b0;
            err_sync_q    <= 1'b0;
            err_ovf_q     <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < TILE_SIZE; i++) acc_q[i] <= acc_d[i];
            beat_cnt_q    <= beat_cnt_d;
            tile_cnt_q    <= tile_cnt_d;
            expect_done_q <= expect_done_d;
            err_sync_q    <= err_sync_d;
            err_ovf_q     <= err_ovf_d;
            fifo_q[0]     <= fifo_d[0];
            fifo_q[1]     <= fifo_d[1];
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_vec   = fifo_q[0].vec;
    assign out_sat   = fifo_q[0].sat;
    assign out_tag   = fifo_q[0].tag;
    assign err_sync  = err_sync_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_mac_tile_reducer.sv
// Directed self-checking bench for mac_tile_reducer: one task per scenario, expected
// values worked out by hand from the Q8 requantization of the driven row sums.
module tb_mac_tile_reducer;

    localparam int TS = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int FB = 8;
    localparam int CB = 16;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic [2:0]                     mode = 3'b000;
    logic                           valid_in = 1'b0;
    logic                           done_tile_in = 1'b0;
    logic [TS-1:0][TS-1:0][AW-1:0]  tile_in = '0;
    logic                           err_clr = 1'b0;
    logic                           out_valid;
    logic                           out_ready = 1'b0;
    logic [TS-1:0][DW-1:0]          out_vec;
    logic                           out_sat;
    logic [7:0]                     out_tag;
    logic                           err_sync;
    logic                           err_ovf;

    int n_cmp = 0;
    int n_fail = 0;
    bit done_pending = 1'b0;

    mac_tile_reducer #(
        .TILE_SIZE(TS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB), .COL_BLOCKS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .valid_in(valid_in),
        .done_tile_in(done_tile_in), .tile_in(tile_in), .err_clr(err_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_sat(out_sat), .out_tag(out_tag), .err_sync(err_sync), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [TS*DW-1:0] make_vec(input int e0, input int e1, input int e2, input int e3);
        return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    endfunction

    // Column 0 of row i carries a + r*i, all other columns carry b.
    task automatic beat(input int a, input int b, input int r, input logic [2:0] m);
        @(negedge clk);
        done_tile_in = done_pending;
        done_pending = 1'b0;
        err_clr      = 1'b0;
        mode         = m;
        valid_in     = 1'b1;
        for (int i = 0; i < TS; i++)
            for (int j = 0; j < TS; j++)
                tile_in[i][j] = (j == 0) ? AW'(a + r * i) : AW'(b);
    endtask

    task automatic idle();
        @(negedge clk);
        done_tile_in = done_pending;
        done_pending = 1'b0;
        err_clr      = 1'b0;
        mode         = 3'b000;
        valid_in     = 1'b0;
    endtask

    task automatic run_tile(input int a, input int b, input int r, input bit with_done);
        for (int k = 0; k < CB; k++) beat(a, b, r, 3'b000);
        done_pending = with_done;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid_in = 1'b0; mode = 3'b000; done_tile_in = 1'b0;
        err_clr = 1'b0; out_ready = 1'b0; done_pending = 1'b0; tile_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_vec !== '0) begin n_fail++; $display("[TB] FAIL reset_vec: got %h want 0", out_vec); end
        n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sat: got %b want 0", out_sat); end
        n_cmp++; if (out_tag !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_tag: got %0d want 0", out_tag); end
        n_cmp++; if ({err_sync, err_ovf} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 00", {err_sync, err_ovf}); end
        rst_n = 1'b1;
        idle();
        n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_idle_sync: got %b want 0", err_sync); end
    endtask

    task automatic test_ones();
        do_reset();
        run_tile(256, 256, 0, 1'b1);
        idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ones_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_vec !== make_vec(64, 64, 64, 64)) begin n_fail++; $display("[TB] FAIL ones_vec: got %h want %h", out_vec, make_vec(64, 64, 64, 64)); end
        n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("[TB] FAIL ones_sat: got %b want 0", out_sat); end
        n_cmp++; if (out_tag !== 8'd0) begin n_fail++; $display("[TB] FAIL ones_tag: got %0d want 0", out_tag); end
        idle();
        n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL ones_sync: got %b want 0", err_sync); end
        n_cmp++; if (out_vec !== make_vec(64, 64, 64, 64) || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ones_hold: got %h/%b want %h/1", out_vec, out_valid, make_vec(64, 64, 64, 64)); end
        out_ready = 1'b1;
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ones_pop: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        run_tile(1 << 24, 1 << 24, 0, 1'b1);
        idle();
        n_cmp++; if (out_vec !== make_vec(32767, 32767, 32767, 32767)) begin n_fail++; $display("[TB] FAIL sat_pos_vec: got %h want %h", out_vec, make_vec(32767, 32767, 32767, 32767)); end
        n_cmp++; if (out_sat !== 1'b1 || out_tag !== 8'd0) begin n_fail++; $display("[TB] FAIL sat_pos_flag: got sat=%b tag=%0d want sat=1 tag=0", out_sat, out_tag); end
        run_tile(-(1 << 24), -(1 << 24), 0, 1'b1);
        idle();
        n_cmp++; if (out_vec !== make_vec(-32768, -32768, -32768, -32768)) begin n_fail++; $display("[TB] FAIL sat_neg_vec: got %h want %h", out_vec, make_vec(-32768, -32768, -32768, -32768)); end
        n_cmp++; if (out_sat !== 1'b1 || out_tag !== 8'd1) begin n_fail++; $display("[TB] FAIL sat_neg_flag: got sat=%b tag=%0d want sat=1 tag=1", out_sat, out_tag); end
        beat(128, 0, 0, 3'b000);
        for (int k = 1; k < CB; k++) beat(0, 0, 0, 3'b000);
        done_pending = 1'b1;
        idle();
        n_cmp++; if (out_vec !== make_vec(1, 1, 1, 1) || out_sat !== 1'b0) begin n_fail++; $display("[TB] FAIL round_up: got %h sat=%b want %h sat=0", out_vec, out_sat, make_vec(1, 1, 1, 1)); end
        beat(-129, 0, 0, 3'b000);
        for (int k = 1; k < CB; k++) beat(0, 0, 0, 3'b000);
        done_pending = 1'b1;
        idle();
        n_cmp++; if (out_vec !== make_vec(-1, -1, -1, -1) || out_tag !== 8'd3) begin n_fail++; $display("[TB] FAIL round_neg: got %h tag=%0d want %h tag=3", out_vec, out_tag, make_vec(-1, -1, -1, -1)); end
        idle();
        n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_sync: got %b want 0", err_sync); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < CB; b++) begin
                beat(256 * (k + 1), 0, 256, 3'b000);
                if (b == 0 && k > 0) begin
                    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'(k - 1)) begin n_fail++; $display("[TB] FAIL b2b_tag%0d: got valid=%b tag=%0d want valid=1 tag=%0d", k - 1, out_valid, out_tag, k - 1); end
                    n_cmp++; if (out_vec !== make_vec(16 * k, 16 * (k + 1), 16 * (k + 2), 16 * (k + 3))) begin n_fail++; $display("[TB] FAIL b2b_vec%0d: got %h want %h", k - 1, out_vec, make_vec(16 * k, 16 * (k + 1), 16 * (k + 2), 16 * (k + 3))); end
                end
            end
            done_pending = 1'b1;
        end
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd2) begin n_fail++; $display("[TB] FAIL b2b_tag2: got valid=%b tag=%0d want valid=1 tag=2", out_valid, out_tag); end
        n_cmp++; if (out_vec !== make_vec(48, 64, 80, 96)) begin n_fail++; $display("[TB] FAIL b2b_vec2: got %h want %h", out_vec, make_vec(48, 64, 80, 96)); end
        idle();
        n_cmp++; if (out_valid !== 1'b0 || err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_end: got valid=%b sync=%b want 0 0", out_valid, err_sync); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 3; k++) run_tile(256 * (k + 1), 0, 0, 1'b1);
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd0) begin n_fail++; $display("[TB] FAIL full_head: got valid=%b tag=%0d want valid=1 tag=0", out_valid, out_tag); end
        n_cmp++; if (out_vec !== make_vec(16, 16, 16, 16)) begin n_fail++; $display("[TB] FAIL full_vec0: got %h want %h", out_vec, make_vec(16, 16, 16, 16)); end
        n_cmp++; if (err_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ovf: got %b want 1", err_ovf); end
        out_ready = 1'b1;
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd1 || out_vec !== make_vec(32, 32, 32, 32)) begin n_fail++; $display("[TB] FAIL full_pop1: got valid=%b tag=%0d vec=%h want 1 1 %h", out_valid, out_tag, out_vec, make_vec(32, 32, 32, 32)); end
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_empty: got %b want 0", out_valid); end
        run_tile(1024, 0, 0, 1'b1);
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd3 || out_vec !== make_vec(64, 64, 64, 64)) begin n_fail++; $display("[TB] FAIL full_gap: got valid=%b tag=%0d vec=%h want 1 3 %h", out_valid, out_tag, out_vec, make_vec(64, 64, 64, 64)); end
        n_cmp++; if (err_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ovf_sticky: got %b want 1", err_ovf); end
        @(negedge clk);
        done_tile_in = 1'b0;
        err_clr = 1'b1;
        idle();
        n_cmp++; if (err_ovf !== 1'b0 || err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL full_clr: got ovf=%b sync=%b want 0 0", err_ovf, err_sync); end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        do_reset();
        run_tile(256, 0, 0, 1'b1);
        run_tile(512, 0, 0, 1'b1);
        for (int k = 0; k < CB; k++) begin
            beat(768, 0, 0, 3'b000);
            if (k == CB - 1) out_ready = 1'b1;
        end
        done_pending = 1'b1;
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd1 || out_vec !== make_vec(32, 32, 32, 32)) begin n_fail++; $display("[TB] FAIL pp_head1: got valid=%b tag=%0d vec=%h want 1 1 %h", out_valid, out_tag, out_vec, make_vec(32, 32, 32, 32)); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_ovf: got %b want 0", err_ovf); end
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd2 || out_vec !== make_vec(48, 48, 48, 48)) begin n_fail++; $display("[TB] FAIL pp_head2: got valid=%b tag=%0d vec=%h want 1 2 %h", out_valid, out_tag, out_vec, make_vec(48, 48, 48, 48)); end
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_sync_errors();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < CB; b++) begin
            beat(256, 256, 0, 3'b000);
            if (b == 5 || b == 9) done_tile_in = 1'b1;
            if (b == 7 || b == 9 || b == 11) err_clr = 1'b1;
            if (b == 6) begin
                n_cmp++; if (err_sync !== 1'b1) begin n_fail++; $display("[TB] FAIL sync_early: got %b want 1", err_sync); end
            end
            if (b == 8 || b == 12) begin
                n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_clr_b%0d: got %b want 0", b, err_sync); end
            end
            if (b == 10) begin
                n_cmp++; if (err_sync !== 1'b1) begin n_fail++; $display("[TB] FAIL sync_set_wins: got %b want 1", err_sync); end
            end
        end
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_vec !== make_vec(64, 64, 64, 64)) begin n_fail++; $display("[TB] FAIL sync_entry: got valid=%b tag=%0d vec=%h want 1 0 %h", out_valid, out_tag, out_vec, make_vec(64, 64, 64, 64)); end
        n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_pre_missing: got %b want 0", err_sync); end
        idle();
        n_cmp++; if (err_sync !== 1'b1) begin n_fail++; $display("[TB] FAIL sync_missing: got %b want 1", err_sync); end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        for (int b = 0; b < 7; b++) beat(256, 256, 0, 3'b000);
        beat(256, 256, 0, 3'b001);
        idle();
        n_cmp++; if (err_sync !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flag: got sync=%b valid=%b want 1 0", err_sync, out_valid); end
        @(negedge clk);
        err_clr = 1'b1;
        mode = 3'b010;
        idle();
        n_cmp++; if (err_sync !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle: got sync=%b valid=%b want 0 0", err_sync, out_valid); end
        run_tile(512, 0, 0, 1'b1);
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_vec !== make_vec(32, 32, 32, 32)) begin n_fail++; $display("[TB] FAIL abort_next: got valid=%b tag=%0d vec=%h want 1 0 %h", out_valid, out_tag, out_vec, make_vec(32, 32, 32, 32)); end
        idle();
        n_cmp++; if (err_sync !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_next_sync: got %b want 0", err_sync); end
    endtask

    task automatic test_reset_midtile();
        for (int b = 0; b < 4; b++) begin
            beat(1000, 1000, 0, 3'b000);
            if (b == 2) done_tile_in = 1'b1;
        end
        n_cmp++; if (err_sync !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre: got sync=%b valid=%b want 1 1", err_sync, out_valid); end
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_vec !== '0 || out_sat !== 1'b0 || out_tag !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_async_out: got valid=%b vec=%h sat=%b tag=%0d want all 0", out_valid, out_vec, out_sat, out_tag); end
        n_cmp++; if (err_sync !== 1'b0 || err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_err: got sync=%b ovf=%b want 0 0", err_sync, err_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        run_tile(256, 256, 0, 1'b1);
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_vec !== make_vec(64, 64, 64, 64)) begin n_fail++; $display("[TB] FAIL rst_restart: got valid=%b tag=%0d vec=%h want 1 0 %h", out_valid, out_tag, out_vec, make_vec(64, 64, 64, 64)); end
        idle();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_saturation();
        test_back_to_back();
        test_fifo_full();
        test_push_pop_full();
        test_sync_errors();
        test_abort();
        test_reset_midtile();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
